// File: rtl/aes_shift_mix_stage.sv
// aes_shift_mix_stage: registered AES round back-end.
// Applies ShiftRows, MixColumns and AddRoundKey to the SubBytes result and
// buffers the round result in a two-entry (main + skid) output store with a
// registered in_ready. Byte i of a 128-bit bus sits at bits [8i:8i+7], and
// the state is column-major (byte i -> row i%4, column i/4).
// Optional feature macro: AES_FINAL_ROUND_EN. When it is defined, in_last = 1
// at accept bypasses MixColumns. When it is undefined, in_last is ignored.
module aes_shift_mix_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic [0:127] in_rkey,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } fill_e;

  // Multiply by x in GF(2^8) using the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Mix one column. col[31:24] holds row 0.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    mix_column[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    mix_column[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    mix_column[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    mix_column[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[(c*4 + r)*8 +: 8] = s[(((c + r) % 4)*4 + r)*8 +: 8];
      end
    end
  endfunction

  // Apply MixColumns to each of the four columns.
  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    for (int c = 0; c < 4; c++) begin
      mix_columns[c*32 +: 32] = mix_column(s[c*32 +: 32]);
    end
  endfunction

  fill_e        state_r, state_nxt_s;
  logic [0:127] main_r, main_nxt_s;
  logic [0:127] skid_r, skid_nxt_s;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         skip_mix_s;
  logic [0:127] shifted_s;
  logic [0:127] result_s;
  logic         accept_s;
  logic         pop_s;

`ifdef AES_FINAL_ROUND_EN
  assign skip_mix_s = in_last;
`else
  // in_last stays on the port but has no effect in this build.
  logic unused_last_s;
  assign unused_last_s = in_last;
  assign skip_mix_s    = 1'b0;
`endif

  assign shifted_s = shift_rows(in_state);
  assign accept_s  = in_valid & in_ready_r;
  assign pop_s     = out_valid_r & out_ready;

  // Round datapath in front of the storage registers.
  always_comb begin
    result_s = 128'h0;
    if (skip_mix_s) begin
      result_s = shifted_s ^ in_rkey;
    end else begin
      result_s = mix_columns(shifted_s) ^ in_rkey;
    end
  end

  // Next-state and next-data for the main/skid store.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_ONE;
          main_nxt_s  = result_s;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && pop_s) begin
          state_nxt_s = ST_ONE;
          main_nxt_s  = result_s;
        end else if (accept_s) begin
          state_nxt_s = ST_TWO;
          skid_nxt_s  = result_s;
        end else if (pop_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a pop can change anything.
        if (pop_s) begin
          state_nxt_s = ST_ONE;
          main_nxt_s  = skid_r;
        end else begin
          state_nxt_s = ST_TWO;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // State, storage and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      main_r      <= 128'h0;
      skid_r      <= 128'h0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_state = main_r;

endmodule
